conv_feeder: RTL

CONV_FEEDER -- requirements
Module: conv_feeder

---
 rtl/conv_feeder.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/conv_feeder.sv
// Convolution job sequencer: streams input/weight words from source memory to the
// accelerator, captures result words into destination memory, reports job status.
module conv_feeder #(
  parameter int unsigned N_IN_WORDS  = 289,
  parameter int unsigned N_W_WORDS   = 36,
  parameter int unsigned N_OUT_WORDS = 256,
  parameter int unsigned TIMEOUT     = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        go,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        src_rd,
  output logic [8:0]  src_addr,
  input  logic [31:0] src_data,
  output logic        start,
  output logic [31:0] i_data,
  output logic        i_valid,
  output logic        d_type,
  input  logic [31:0] o_data,
  input  logic        o_valid,
  input  logic        finish,
  output logic        dst_we,
  output logic [7:0]  dst_addr,
  output logic [31:0] dst_data
);

  localparam int unsigned N_TOTAL = N_IN_WORDS + N_W_WORDS;
  localparam int unsigned RD_W    = 10;
  localparam int unsigned OUT_W   = 9;
  localparam int unsigned TMO_W   = 16;

  typedef enum logic [4:0] {
    S_IDLE  = 5'b00001,
    S_START = 5'b00010,
    S_LOAD  = 5'b00100,
    S_WAIT  = 5'b01000,
    S_DONE  = 5'b10000
  } state_t;

  state_t            state;
  logic [RD_W-1:0]   rd_cnt;
  logic [OUT_W-1:0]  out_cnt;
  logic [OUT_W-1:0]  out_cnt_n;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              ovf;
  logic              ovf_n;
  logic              early;
  logic              early_n;
  logic              capturing;
  logic              cap_ok;
  logic              tmo_hit;
  logic              err_n;

  // Source data arrives one cycle after the read, so it is forwarded while i_valid is high.
  assign i_data = i_valid ? src_data : 32'h0;

  // Next values of the status trackers, so a result word or finish landing in the
  // completion cycle is already reflected in err.
  always_comb begin
    capturing = (state == S_LOAD) || (state == S_WAIT);
    cap_ok    = capturing && o_valid && (out_cnt < OUT_W'(N_OUT_WORDS));
    out_cnt_n = cap_ok ? out_cnt + OUT_W'(1) : out_cnt;
    ovf_n     = ovf | (capturing && o_valid && (out_cnt >= OUT_W'(N_OUT_WORDS)));
    early_n   = early | ((state == S_LOAD) && finish);
    tmo_hit   = (state == S_WAIT) && !finish &&
                (({1'b0, tmo_cnt} + 17'd1) >= 17'(TIMEOUT));
    err_n     = ovf_n | tmo_hit | early_n | (out_cnt_n != OUT_W'(N_OUT_WORDS));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      src_rd   <= 1'b0;
      src_addr <= '0;
      start    <= 1'b0;
      i_valid  <= 1'b0;
      d_type   <= 1'b0;
      dst_we   <= 1'b0;
      dst_addr <= '0;
      dst_data <= '0;
      rd_cnt   <= '0;
      out_cnt  <= '0;
      tmo_cnt  <= '0;
      ovf      <= 1'b0;
      early    <= 1'b0;
    end else begin
      start    <= 1'b0;
      done     <= 1'b0;
      src_rd   <= 1'b0;
      src_addr <= '0;
      i_valid  <= src_rd;
      d_type   <= src_rd && (src_addr >= 9'(N_IN_WORDS));
      dst_we   <= cap_ok;
      dst_addr <= cap_ok ? out_cnt[7:0] : 8'h0;
      dst_data <= cap_ok ? o_data : 32'h0;
      out_cnt  <= out_cnt_n;
      ovf      <= ovf_n;
      early    <= early_n;

      // Read issue continues from START through LOAD until every word is requested.
      if (((state == S_START) || (state == S_LOAD)) && (rd_cnt < RD_W'(N_TOTAL))) begin
        src_rd   <= 1'b1;
        src_addr <= rd_cnt[8:0];
        rd_cnt   <= rd_cnt + RD_W'(1);
      end

      case (state)
        S_IDLE: begin
          if (go) begin
            state    <= S_START;
            busy     <= 1'b1;
            start    <= 1'b1;
            src_rd   <= 1'b1;
            src_addr <= '0;
            rd_cnt   <= RD_W'(1);
            out_cnt  <= '0;
            tmo_cnt  <= '0;
            ovf      <= 1'b0;
            early    <= 1'b0;
            err      <= 1'b0;
          end
        end
        S_START: state <= S_LOAD;
        S_LOAD: begin
          // Last word is on i_valid with no read outstanding behind it.
          if (i_valid && !src_rd) begin
            tmo_cnt <= '0;
            if (early_n) begin
              state <= S_DONE;
              done  <= 1'b1;
              err   <= err_n;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          tmo_cnt <= (tmo_cnt == '1) ? tmo_cnt : tmo_cnt + TMO_W'(1);
          if (finish || tmo_hit) begin
            state <= S_DONE;
            done  <= 1'b1;
            err   <= err_n;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
